// File: rtl/evm_ballot_capture_if.sv
// Bus between the ballot front-end and whatever drives the raw controls /
// consumes the conditioned vote. The master owns the raw button, selector and
// session gate; the slave (the capture stage) owns the conditioned outputs.
interface evm_ballot_capture_if;
  logic       raw_btn;
  logic [2:0] raw_sel;
  logic       session_en;
  logic [2:0] vote_input;
  logic       btn;
  logic       busy;
  logic       ignored_press;

  modport master (
    output raw_btn, raw_sel, session_en,
    input  vote_input, btn, busy, ignored_press
  );

  modport slave (
    input  raw_btn, raw_sel, session_en,
    output vote_input, btn, busy, ignored_press
  );
endinterface

// File: rtl/evm_ballot_capture.sv
// Ballot capture front-end: synchronises and debounces the voter button,
// latches the candidate selector on an accepted press, and emits one btn
// strobe per press, with session gating and a post-vote lockout.
module evm_ballot_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  evm_ballot_capture_if.slave  cap
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LK_W = $clog2(LOCKOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    LOCKOUT = 2'd2,
    RELEASE = 2'd3
  } state_e;

  logic            btn_meta_q, sync_btn_q;
  logic [2:0]      sel_meta_q, sync_sel_q;
  logic            db_btn_q, db_btn_d;
  logic            db_dly_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [2:0]      vote_q, vote_d;
  logic            ign_q, ign_d;
  state_e          state_q, state_d;
  logic            press;

  // Two-flop synchronisers for the asynchronous button and selector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      sync_btn_q <= 1'b0;
      sel_meta_q <= 3'b000;
      sync_sel_q <= 3'b000;
    end else begin
      btn_meta_q <= cap.raw_btn;
      sync_btn_q <= btn_meta_q;
      sel_meta_q <= cap.raw_sel;
      sync_sel_q <= sel_meta_q;
    end
  end

  // Debounce: the filtered button only follows after a run of stable cycles.
  always_comb begin
    db_btn_d = db_btn_q;
    db_cnt_d = '0;
    if (sync_btn_q != db_btn_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_btn_d = sync_btn_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_btn_q & ~db_dly_q;

  // Capture FSM next state: commit, lockout countdown, wait for release.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    vote_d     = vote_q;
    ign_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (cap.session_en) begin
            state_d = COMMIT;
            vote_d  = sync_sel_q;
          end else begin
            ign_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d    = LOCKOUT;
        lock_cnt_d = LK_W'(LOCKOUT_CYCLES);
      end
      LOCKOUT: begin
        ign_d      = press;
        lock_cnt_d = lock_cnt_q - 1'b1;
        if (lock_cnt_q <= LK_W'(1)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!db_btn_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_btn_q   <= 1'b0;
      db_dly_q   <= 1'b0;
      db_cnt_q   <= '0;
      lock_cnt_q <= '0;
      vote_q     <= 3'b000;
      ign_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      db_btn_q   <= db_btn_d;
      db_dly_q   <= db_btn_q;
      db_cnt_q   <= db_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      vote_q     <= vote_d;
      ign_q      <= ign_d;
      state_q    <= state_d;
    end
  end

  assign cap.vote_input    = vote_q;
  assign cap.btn           = (state_q == COMMIT);
  assign cap.busy          = (state_q != IDLE);
  assign cap.ignored_press = ign_q;

endmodule

// File: tb/tb_evm_ballot_capture.sv
// Self-checking bench for evm_ballot_capture: table of clean presses plus
// hand-written glitch, lockout re-press and mid-lockout reset sequences.
// Every btn strobe is matched against a queue of expected selections.
module tb_evm_ballot_capture;

  logic clk = 1'b0;
  logic rst_n;

  // 10 ns clock.
  always #5 clk = ~clk;

  evm_ballot_capture_if capIf ();

  evm_ballot_capture #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cap  (capIf)
  );

  typedef struct {
    logic [2:0] sel;
    logic       sess;
    logic       expBtn;
    logic       expIgn;
    logic [2:0] expVote;
  } vec_t;

  int         vecCount = 0;
  int         missCount = 0;
  int         btnSeen = 0;
  int         ignSeen = 0;
  logic [2:0] expVoteQ[$];
  vec_t       vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe must consume one expected selection.
  always @(negedge clk) begin
    if (capIf.ignored_press === 1'b1) ignSeen++;
    if (capIf.btn === 1'b1) begin
      btnSeen++;
      if (expVoteQ.size() == 0) checkOutput("btnUnexpected", capIf.btn, 1'b0);
      else checkOutput("btnVote", capIf.vote_input, expVoteQ.pop_front());
    end
  end

  // Wait (bounded) for the FSM to return to IDLE and the button to settle.
  task automatic waitIdle();
    int n;
    n = 0;
    tick(1);
    while (capIf.busy === 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    checkOutput("idleTimeout", capIf.busy, 1'b0);
    tick(10);
  endtask

  // One clean press held 20 cycles; edge numbering starts at the first
  // edge that samples raw_btn=1, so btn is expected right after edge 7.
  task automatic applyStimulus(input vec_t v);
    int b0, i0;
    b0 = btnSeen;
    i0 = ignSeen;
    capIf.raw_sel    = v.sel;
    capIf.session_en = v.sess;
    tick(3);
    if (v.expBtn) expVoteQ.push_back(v.sel);
    capIf.raw_btn = 1'b1;
    tick(6);
    checkOutput("btnEarly", capIf.btn, 1'b0);
    checkOutput("ignEarly", capIf.ignored_press, 1'b0);
    tick(1);
    checkOutput("btnEdge7", capIf.btn, v.expBtn);
    checkOutput("ignEdge7", capIf.ignored_press, v.expIgn);
    if (v.expBtn) checkOutput("voteEdge7", capIf.vote_input, v.sel);
    tick(1);
    checkOutput("btnEdge8", capIf.btn, 1'b0);
    checkOutput("busyEdge8", capIf.busy, v.expBtn);
    tick(12);
    checkOutput("busyHeld", capIf.busy, v.expBtn);
    capIf.raw_btn = 1'b0;
    waitIdle();
    checkOutput("btnCount", btnSeen - b0, v.expBtn);
    checkOutput("ignCount", ignSeen - i0, v.expIgn);
    checkOutput("voteHold", capIf.vote_input, v.expVote);
  endtask

  initial begin
    int   b0, i0;
    vec_t v;

    vecs[0] = '{3'b001, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[1] = '{3'b100, 1'b0, 1'b0, 1'b1, 3'b001};
    vecs[2] = '{3'b011, 1'b1, 1'b1, 1'b0, 3'b011};
    vecs[3] = '{3'b000, 1'b1, 1'b1, 1'b0, 3'b000};
    vecs[4] = '{3'b111, 1'b1, 1'b1, 1'b0, 3'b111};
    vecs[5] = '{3'b110, 1'b0, 1'b0, 1'b1, 3'b111};

    rst_n            = 1'b0;
    capIf.raw_btn    = 1'b0;
    capIf.raw_sel    = 3'b000;
    capIf.session_en = 1'b0;
    tick(2);
    checkOutput("rstBtn", capIf.btn, 1'b0);
    checkOutput("rstBusy", capIf.busy, 1'b0);
    checkOutput("rstIgn", capIf.ignored_press, 1'b0);
    checkOutput("rstVote", capIf.vote_input, 3'b000);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Bounce: 1/0 every 2 cycles never stays stable long enough.
    $display("[TB] glitch sequence");
    b0 = btnSeen;
    i0 = ignSeen;
    capIf.session_en = 1'b1;
    capIf.raw_sel    = 3'b010;
    for (int i = 0; i < 12; i++) begin
      capIf.raw_btn = ((i % 4) < 2);
      tick(1);
    end
    capIf.raw_btn = 1'b0;
    tick(10);
    checkOutput("glitchBtn", btnSeen - b0, 0);
    checkOutput("glitchIgn", ignSeen - i0, 0);
    checkOutput("glitchBusy", capIf.busy, 1'b0);

    // Vote 010, release, re-press early in lockout: refused once.
    $display("[TB] lockout re-press sequence");
    b0 = btnSeen;
    i0 = ignSeen;
    capIf.raw_sel = 3'b010;
    tick(3);
    expVoteQ.push_back(3'b010);
    capIf.raw_btn = 1'b1;
    tick(4);
    capIf.raw_btn = 1'b0;
    tick(3);
    checkOutput("lockBtnEdge7", capIf.btn, 1'b1);
    checkOutput("lockVote", capIf.vote_input, 3'b010);
    tick(1);
    capIf.raw_btn = 1'b1;
    tick(10);
    checkOutput("lockBtnCount", btnSeen - b0, 1);
    checkOutput("lockIgnCount", ignSeen - i0, 1);
    checkOutput("lockBusyRelease", capIf.busy, 1'b1);
    capIf.raw_btn = 1'b0;
    waitIdle();
    v = '{3'b101, 1'b1, 1'b1, 1'b0, 3'b101};
    applyStimulus(v);

    // Reset during lockout with the button held: clears, then re-commits.
    $display("[TB] reset-in-lockout sequence");
    b0 = btnSeen;
    capIf.raw_sel = 3'b110;
    tick(3);
    expVoteQ.push_back(3'b110);
    capIf.raw_btn = 1'b1;
    tick(10);
    checkOutput("preRstBusy", capIf.busy, 1'b1);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midRstBtn", capIf.btn, 1'b0);
    checkOutput("midRstBusy", capIf.busy, 1'b0);
    checkOutput("midRstIgn", capIf.ignored_press, 1'b0);
    checkOutput("midRstVote", capIf.vote_input, 3'b000);
    rst_n = 1'b1;
    expVoteQ.push_back(3'b110);
    tick(6);
    checkOutput("reBtnEarly", capIf.btn, 1'b0);
    tick(1);
    checkOutput("reBtnEdge7", capIf.btn, 1'b1);
    checkOutput("reVote", capIf.vote_input, 3'b110);
    tick(12);
    capIf.raw_btn = 1'b0;
    waitIdle();
    checkOutput("rstBtnCount", btnSeen - b0, 2);

    checkOutput("scoreboardDrained", expVoteQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
